// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/sequencing stage: datapath width,
// ALU opcodes and the sequencer state encoding.
package alu_pkg;

  localparam int W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MRST  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_RESP  = 3'd4
  } seqState_t;

  // Only the mod op is iterative and needs the restart/wait sequence.
  function automatic logic isModOp(input logic [2:0] op);
    return op == OP_MOD;
  endfunction

endpackage

// File: rtl/op_timer.sv
// Cycle counter for the mod wait: cleared by the restart state, counts while
// enabled, and flags the last cycle of the budget. It parks at the terminal
// value so it can never wrap inside one operation.
module op_timer #(
  parameter int MOD_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(MOD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MOD_CYCLES - 1);

  logic [CW-1:0] count;

  // Counter register: clear on reset/restart, advance until terminal count.
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (en && !done) count <= count + CW'(1);
  end

  assign done = (count == LAST);

endmodule

// File: rtl/alu_issue_seq.sv
// Issue stage in front of the 32-bit ALU: takes one request at a time, holds
// the operands on the ALU inputs, runs the restart/wait sequence for mod, and
// presents the captured result on a valid/ready response channel.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int MOD_CYCLES = 32
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_A,
  input  logic [W-1:0] req_B,
  input  logic [2:0]   req_op,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [2:0]   alu_op,
  output logic         alu_rst,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_op,
  output logic         busy
);

  seqState_t stateQ, stateD;
  logic      accept;
  logic      capture;
  logic      tmrClear;
  logic      tmrEn;
  logic      tmrDone;

  // Held low during reset so upstream never sees a handshake that gets dropped.
  assign req_ready = (stateQ == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (stateQ == ST_RESP);
  assign busy      = (stateQ != ST_IDLE);
  // Decoded from registered state so the mod restart pulse is glitch-free.
  assign alu_rst   = reset || (stateQ == ST_MRST);

  op_timer #(.MOD_CYCLES(MOD_CYCLES)) uTimer (
    .clk   (CLK),
    .reset (reset),
    .clear (tmrClear),
    .en    (tmrEn),
    .done  (tmrDone)
  );

  // Next-state and control decode.
  always_comb begin
    stateD   = stateQ;
    capture  = 1'b0;
    tmrClear = 1'b0;
    tmrEn    = 1'b0;
    case (stateQ)
      ST_IDLE:  if (accept) stateD = isModOp(req_op) ? ST_MRST : ST_EXEC;
      ST_EXEC: begin
        capture = 1'b1;
        stateD  = ST_RESP;
      end
      ST_MRST: begin
        tmrClear = 1'b1;
        stateD   = ST_MWAIT;
      end
      ST_MWAIT: begin
        tmrEn = 1'b1;
        if (tmrDone) begin
          capture = 1'b1;
          stateD  = ST_RESP;
        end
      end
      ST_RESP:  if (rsp_ready) stateD = ST_IDLE;
      default:  stateD = ST_IDLE;
    endcase
  end

  // State, operand hold and response capture registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stateQ     <= ST_IDLE;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_op     <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        alu_A  <= req_A;
        alu_B  <= req_B;
        alu_op <= req_op;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_op     <= alu_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq with a behavioural ALU (iterative mod unit that is
// only valid MOD_CYCLES cycles after its restart). Scoreboard + monitor.
module tb_alu_issue_seq;

  localparam int MC = 32;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_A = '0, req_B = '0;
  logic [2:0]  req_op = '0;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [2:0]  alu_op;
  logic        alu_rst;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        busy;

  alu_issue_seq #(.MOD_CYCLES(MC)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_rst(alu_rst),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural ALU: mod result only appears once the unit has run MC cycles.
  int modCnt = 0;
  always @(posedge CLK) begin
    if (alu_rst) modCnt <= 0;
    else if (modCnt < 1000) modCnt <= modCnt + 1;
  end

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      3'b000: alu_result = alu_A & alu_B;
      3'b001: alu_result = alu_A | alu_B;
      3'b010: alu_result = alu_A ^ alu_B;
      3'b011: alu_result = ~(alu_A | alu_B);
      3'b100: alu_result = ($signed(alu_A) < $signed(alu_B)) ? 32'h1 : 32'h0;
      3'b101: alu_result = alu_A + alu_B;
      3'b110: alu_result = alu_A - alu_B;
      default: alu_result = (modCnt >= MC - 1) ?
                            ((alu_B == 0) ? 32'h0 : alu_A % alu_B) : 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   nCmp = 0;
  int   nBad = 0;
  bit   seenV = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first valid cycle, data/op on handshake.
  always @(negedge CLK) begin
    #1;
    if (reset) seenV = 0;
    else if (rsp_valid) begin
      if (sbq.size() == 0) begin
        nCmp++; nBad++;
        $display("FAIL unexpected_rsp: got 0x%08h want none (cycle %0d)", rsp_result, cyc);
      end else begin
        if (!seenV) begin
          chk("rsp_latency", 32'(cyc), 32'(sbq[0].due));
          seenV = 1;
        end
        if (rsp_ready) begin
          exp_t it;
          it = sbq.pop_front();
          chk("rsp_result", rsp_result, it.res);
          chk("rsp_op", {29'b0, rsp_op}, {29'b0, it.op});
          seenV = 0;
        end
      end
    end
  end

  // Present a request at a negedge and wait (bounded) until it will be accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] expRes, input int lat, input bit push,
                       output int tAcc);
    int k;
    exp_t it;
    @(negedge CLK);
    req_A = a; req_B = b; req_op = op; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (k == 200) chk("accept_timeout", 32'(k), 32'd0);
    tAcc = cyc;
    if (push) begin
      it.res = expRes; it.op = op; it.due = tAcc + lat;
      sbq.push_back(it);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] expRes, input int lat);
    int t;
    issue(a, b, op, expRes, lat, 1'b1, t);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (k == 200) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int t, t2;
    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_alu_rst", {31'b0, alu_rst}, 32'd1);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("idle_rsp_result", rsp_result, 32'd0);
    chk("idle_alu_A", alu_A, 32'd0);
    chk("idle_alu_rst", {31'b0, alu_rst}, 32'd0);

    // Single-cycle ops
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 2);
    drain();
    send(32'd5, 32'd7, 3'b110, 32'hFFFFFFFE, 2);
    drain();
    send(32'hFFFFFFFF, 32'd1, 3'b100, 32'h00000001, 2);
    drain();
    send(32'h12345678, 32'h0F0F0F0F, 3'b010, 32'h1D3B5977, 2);
    drain();
    send(32'h0, 32'h0, 3'b011, 32'hFFFFFFFF, 2);
    drain();

    // Iterative mod: restart pulse exactly at t+1, busy through t+34
    issue(32'd17, 32'd5, 3'b111, 32'd2, MC + 2, 1'b1, t);
    for (int i = 1; i <= MC + 3; i++) begin
      @(negedge CLK);
      if (i == 1) req_valid = 1'b0;
      chk($sformatf("mod_alu_rst_t%0d", i), {31'b0, alu_rst}, {31'b0, (i == 1)});
      chk($sformatf("mod_busy_t%0d", i), {31'b0, busy}, {31'b0, (i <= MC + 2)});
    end
    drain();

    // Backpressure, then back-to-back request accepted right after handshake
    rsp_ready = 1'b0;
    issue(32'h7FFFFFFF, 32'd1, 3'b101, 32'h80000000, 2, 1'b1, t);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_result", rsp_result, 32'h80000000);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      if (i < 2) @(negedge CLK);
    end
    rsp_ready = 1'b1;
    req_A = 32'h000000FF; req_B = 32'h0000000F; req_op = 3'b010; req_valid = 1'b1;
    issue(32'h000000FF, 32'h0000000F, 3'b010, 32'h000000F0, 2, 1'b1, t2);
    chk("b2b_accept_cycle", 32'(t2), 32'(t + 5));
    @(negedge CLK);
    req_valid = 1'b0;
    drain();

    // Reset while in MWAIT with counter at 10: no response, clean IDLE
    issue(32'd100, 32'd7, 3'b111, 32'd0, 0, 1'b0, t);
    @(negedge CLK);
    req_valid = 1'b0;
    while (cyc < t + 12) @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("rst_mid_alu_rst", {31'b0, alu_rst}, 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mid_rsp_result", rsp_result, 32'd0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    send(32'h1, 32'h2, 3'b001, 32'h3, 2);
    drain();

    // req_valid held while busy with changing A: only accept-cycle data used
    issue(32'd10, 32'd20, 3'b101, 32'd30, 2, 1'b1, t);
    @(negedge CLK);
    req_A = 32'd111;
    issue(32'd222, 32'd20, 3'b101, 32'd242, 2, 1'b1, t2);
    chk("held_valid_accept_cycle", 32'(t2), 32'(t + 3));
    @(negedge CLK);
    req_valid = 1'b0;
    drain();
    repeat (5) @(negedge CLK);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
